// File: rtl/spp_host_pkg.sv
// spp_host shared types: request op codes, FSM states, timing floors
// and the strobe pattern each state drives.
package spp_host_pkg;

  localparam logic [1:0] OP_SETADDR = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  localparam int MIN_STROBE_CYC  = 3;
  localparam int MIN_RECOVER_CYC = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADR_LO,
    S_ADR_HI,
    S_WR_LO,
    S_WR_HI,
    S_RD0_LO,
    S_RD0_HI,
    S_RD1_LO,
    S_RD1_HI,
    S_INC_LO,
    S_INC_HI
  } spp_host_state;

  // {wrextb, rdextb}
  function automatic logic [1:0] strobe_pat(spp_host_state s);
    logic [1:0] p;
    p = 2'b11;
    case (s)
      S_ADR_LO, S_INC_LO: p = 2'b00;
      S_WR_LO:            p = 2'b01;
      S_RD0_LO, S_RD1_LO: p = 2'b10;
      default:            p = 2'b11;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/spp_host_if.sv
// Request/response handshake plus parallel-port bus of spp_host.
// slave = host side, master = requester and board-side target.
interface spp_host_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] pp_data;
  logic       wrextb;
  logic       rdextb;
  logic [3:0] pp_din;

  modport slave (
    input  req_valid, req_op, req_data, pp_din,
    output req_ready, rsp_valid, rsp_data,
    output pp_data, wrextb, rdextb
  );

  modport master (
    output req_valid, req_op, req_data, pp_din,
    input  req_ready, rsp_valid, rsp_data,
    input  pp_data, wrextb, rdextb
  );
endinterface

// File: rtl/spp_phase_timer.sv
// Loadable down-counter timing one strobe phase; done while at zero.
module spp_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/spp_host.sv
// SRAM parallel-port host: byte requests -> wrextb/rdextb strobe phases.
// SPP_HOST_AUTOINC_EN adds a shadow address re-sent +1 after WRITE/READ.
module spp_host
  import spp_host_pkg::*;
#(
  parameter int STROBE_CYC  = 4,
  parameter int RECOVER_CYC = 6
) (
  input logic       clk,
  input logic       rstb,
  spp_host_if.slave bus
);

  localparam int TW = 8;
  localparam int LO_N = (STROBE_CYC < MIN_STROBE_CYC) ?
                        MIN_STROBE_CYC : STROBE_CYC;
  localparam int HI_N = (RECOVER_CYC < MIN_RECOVER_CYC) ?
                        MIN_RECOVER_CYC : RECOVER_CYC;
  localparam logic [TW-1:0] LO_LD = TW'(LO_N - 1);
  localparam logic [TW-1:0] HI_LD = TW'(HI_N - 1);

  spp_host_state st, nxt;
  logic          ld;
  logic [TW-1:0] ld_val;
  logic          done;
  logic          accept;
  logic          cap_lo;
  logic          cap_rsp;
  logic [3:0]    lo_nib;
`ifdef SPP_HOST_AUTOINC_EN
  logic          inc;
  logic [7:0]    shadow;
`endif

  spp_phase_timer #(.W(TW)) u_tmr (
    .clk  (clk),
    .rstb (rstb),
    .load (ld),
    .val  (ld_val),
    .done (done)
  );

  always_comb begin
    nxt     = st;
    ld      = 1'b0;
    ld_val  = LO_LD;
    accept  = 1'b0;
    cap_lo  = 1'b0;
    cap_rsp = 1'b0;
`ifdef SPP_HOST_AUTOINC_EN
    inc     = 1'b0;
`endif
    unique case (st)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          ld     = 1'b1;
          unique case (bus.req_op)
            OP_SETADDR: nxt = S_ADR_LO;
            OP_WRITE:   nxt = S_WR_LO;
            OP_READ:    nxt = S_RD0_LO;
            default: begin
              nxt = S_IDLE;
              ld  = 1'b0;
            end
          endcase
        end
      end
      S_ADR_LO, S_WR_LO, S_RD0_LO,
      S_RD1_LO, S_INC_LO: begin
        if (done) begin
          ld     = 1'b1;
          ld_val = HI_LD;
          unique case (st)
            S_ADR_LO: nxt = S_ADR_HI;
            S_WR_LO:  nxt = S_WR_HI;
            S_RD0_LO: nxt = S_RD0_HI;
            S_RD1_LO: nxt = S_RD1_HI;
            default:  nxt = S_INC_HI;
          endcase
        end
      end
      S_RD0_HI: begin
        if (done) begin
          cap_lo = 1'b1;
          ld     = 1'b1;
          nxt    = S_RD1_LO;
        end
      end
      S_WR_HI, S_RD1_HI: begin
        if (done) begin
          cap_rsp = (st == S_RD1_HI);
`ifdef SPP_HOST_AUTOINC_EN
          inc = 1'b1;
          ld  = 1'b1;
          nxt = S_INC_LO;
`else
          nxt = S_IDLE;
`endif
        end
      end
      S_ADR_HI, S_INC_HI: begin
        if (done) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st            <= S_IDLE;
      bus.wrextb    <= 1'b1;
      bus.rdextb    <= 1'b1;
      bus.req_ready <= 1'b1;
      bus.pp_data   <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      lo_nib        <= '0;
    end else begin
      st            <= nxt;
      {bus.wrextb, bus.rdextb} <= strobe_pat(nxt);
      bus.req_ready <= (nxt == S_IDLE);
      bus.rsp_valid <= cap_rsp;
      if (accept) bus.pp_data <= bus.req_data;
`ifdef SPP_HOST_AUTOINC_EN
      if (inc) bus.pp_data <= shadow + 8'd1;
`endif
      if (cap_lo) lo_nib <= bus.pp_din;
      if (cap_rsp) bus.rsp_data <= {bus.pp_din, lo_nib};
    end
  end

`ifdef SPP_HOST_AUTOINC_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shadow <= '0;
    end else if (inc) begin
      shadow <= shadow + 8'd1;
    end else if (accept && bus.req_op == OP_SETADDR) begin
      shadow <= bus.req_data;
    end
  end
`endif

endmodule

// File: tb/tb_spp_host.sv
// Directed bench for spp_host with a behavioural board-side target.
// Define SPP_HOST_AUTOINC_EN to also cover the address auto-increment.
module tb_spp_host;

`ifdef SPP_HOST_AUTOINC_EN
  localparam int WR_CYC = 21;
  localparam int RD_CYC = 31;
`else
  localparam int WR_CYC = 11;
  localparam int RD_CYC = 21;
`endif

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   total = 0;
  int   bad = 0;

  spp_host_if bus();

  spp_host #(.STROBE_CYC(4), .RECOVER_CYC(6)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // board-side target: reacts to the first cycle of each strobe pattern
  logic [7:0] mem [0:255];
  logic [7:0] taddr;
  logic       nib;
  logic       pw, pr;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      taddr      <= 8'h00;
      nib        <= 1'b0;
      pw         <= 1'b1;
      pr         <= 1'b1;
      bus.pp_din <= 4'h0;
    end else begin
      pw <= bus.wrextb;
      pr <= bus.rdextb;
      if (pw && pr) begin
        if (!bus.wrextb && !bus.rdextb) begin
          taddr <= bus.pp_data;
          nib   <= 1'b0;
        end else if (!bus.wrextb) begin
          mem[taddr] <= bus.pp_data;
          nib        <= 1'b0;
        end else if (!bus.rdextb) begin
          bus.pp_din <= nib ? mem[taddr][7:4] : mem[taddr][3:0];
          nib        <= ~nib;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout: req_ready=%b want 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // called on cycle 1 after acceptance; returns on first ready cycle
  task automatic wait_idle(output int cyc, output int np,
                           output int pc, output logic [7:0] pd);
    cyc = 1;
    np  = 0;
    pc  = 0;
    pd  = 8'h00;
    forever begin
      if (bus.rsp_valid) begin
        np++;
        pc = cyc;
        pd = bus.rsp_data;
      end
      if (bus.req_ready || cyc > 200) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic xact(input logic [1:0] op, input logic [7:0] d,
                      output int cyc, output int np,
                      output int pc, output logic [7:0] pd);
    send(op, d);
    wait_idle(cyc, np, pc, pd);
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_data  = 8'h00;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    total += 6;
    if (bus.wrextb !== 1'b1) begin
      bad++; $display("FAIL rst_wrextb: got %b want 1", bus.wrextb);
    end
    if (bus.rdextb !== 1'b1) begin
      bad++; $display("FAIL rst_rdextb: got %b want 1", bus.rdextb);
    end
    if (bus.pp_data !== 8'h00) begin
      bad++; $display("FAIL rst_pp_data: got %h want 00", bus.pp_data);
    end
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    if (bus.rsp_data !== 8'h00) begin
      bad++; $display("FAIL rst_rsp_data: got %h want 00", bus.rsp_data);
    end
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_read_zero;
    int c, np, pc;
    logic [7:0] pd;
    xact(2'd2, 8'h00, c, np, pc, pd);
    total += 3;
    if (np !== 1) begin
      bad++; $display("FAIL rd0_pulses: got %0d want 1", np);
    end
    if (pd !== 8'h00) begin
      bad++; $display("FAIL rd0_data: got %h want 00", pd);
    end
    if (c !== RD_CYC) begin
      bad++; $display("FAIL rd0_len: got %0d want %0d", c, RD_CYC);
    end
  endtask

  task automatic test_setaddr;
    int c, np, pc;
    logic [7:0] pd;
    send(2'd0, 8'h02);
    total += 2;
    if ({bus.wrextb, bus.rdextb} !== 2'b00) begin
      bad++;
      $display("FAIL adr_lo_strobes: got %b%b want 00",
               bus.wrextb, bus.rdextb);
    end
    if (bus.pp_data !== 8'h02) begin
      bad++; $display("FAIL adr_pp_data: got %h want 02", bus.pp_data);
    end
    wait_idle(c, np, pc, pd);
    total += 4;
    if (c !== 11) begin
      bad++; $display("FAIL adr_len: got %0d want 11", c);
    end
    if ({bus.wrextb, bus.rdextb} !== 2'b11) begin
      bad++;
      $display("FAIL adr_end_strobes: got %b%b want 11",
               bus.wrextb, bus.rdextb);
    end
    if (taddr !== 8'h02) begin
      bad++; $display("FAIL adr_target: got %h want 02", taddr);
    end
    if (np !== 0) begin
      bad++; $display("FAIL adr_rsp: got %0d pulses want 0", np);
    end
  endtask

  task automatic test_write;
    int c, np, pc;
    logic [7:0] pd;
    xact(2'd0, 8'h01, c, np, pc, pd);
    send(2'd1, 8'hA5);
    total++;
    if ({bus.wrextb, bus.rdextb} !== 2'b01) begin
      bad++;
      $display("FAIL wr_lo_strobes: got %b%b want 01",
               bus.wrextb, bus.rdextb);
    end
    wait_idle(c, np, pc, pd);
    total += 2;
    if (c !== WR_CYC) begin
      bad++; $display("FAIL wr_len: got %0d want %0d", c, WR_CYC);
    end
    if (mem[1] !== 8'hA5) begin
      bad++; $display("FAIL wr_reg1: got %h want a5", mem[1]);
    end
    xact(2'd0, 8'h02, c, np, pc, pd);
    xact(2'd1, 8'h3C, c, np, pc, pd);
    total += 2;
    if (mem[2] !== 8'h3C) begin
      bad++; $display("FAIL wr_reg2: got %h want 3c", mem[2]);
    end
    if (mem[1] !== 8'hA5) begin
      bad++; $display("FAIL wr_reg1_kept: got %h want a5", mem[1]);
    end
  endtask

  task automatic test_read;
    int c, np, pc;
    logic [7:0] pd;
    xact(2'd0, 8'h01, c, np, pc, pd);
    send(2'd2, 8'h00);
    total++;
    if ({bus.wrextb, bus.rdextb} !== 2'b10) begin
      bad++;
      $display("FAIL rd_lo_strobes: got %b%b want 10",
               bus.wrextb, bus.rdextb);
    end
    wait_idle(c, np, pc, pd);
    total += 4;
    if (np !== 1) begin
      bad++; $display("FAIL rd_pulses: got %0d want 1", np);
    end
    if (pc !== 21) begin
      bad++; $display("FAIL rd_latency: got %0d want 21", pc);
    end
    if (pd !== 8'hA5) begin
      bad++; $display("FAIL rd_data: got %h want a5", pd);
    end
    if (c !== RD_CYC) begin
      bad++; $display("FAIL rd_len: got %0d want %0d", c, RD_CYC);
    end
    @(negedge clk);
    total += 2;
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rd_pulse_width: got %b want 0", bus.rsp_valid);
    end
    if (bus.rsp_data !== 8'hA5) begin
      bad++; $display("FAIL rd_hold: got %h want a5", bus.rsp_data);
    end
  endtask

  task automatic test_reserved;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd3;
    bus.req_data  = 8'hEE;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total += 3;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL rsv_ready: got %b want 1", bus.req_ready);
    end
    if ({bus.wrextb, bus.rdextb} !== 2'b11) begin
      bad++;
      $display("FAIL rsv_strobes: got %b%b want 11",
               bus.wrextb, bus.rdextb);
    end
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rsv_rsp: got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    int n, c, np, pc;
    logic [7:0] pd;
    send(2'd0, 8'h04);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd1;
    bus.req_data  = 8'h5A;
    n = 1;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total += 2;
    if (n !== 11) begin
      bad++; $display("FAIL b2b_gap: got %0d want 11", n);
    end
    if ({bus.wrextb, bus.rdextb} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_idle_strobes: got %b%b want 11",
               bus.wrextb, bus.rdextb);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if ({bus.req_ready, bus.wrextb, bus.rdextb} !== 3'b001) begin
      bad++;
      $display("FAIL b2b_accept: got %b%b%b want 001",
               bus.req_ready, bus.wrextb, bus.rdextb);
    end
    wait_idle(c, np, pc, pd);
    total += 2;
    if (c !== WR_CYC) begin
      bad++; $display("FAIL b2b_wr_len: got %0d want %0d", c, WR_CYC);
    end
    if (mem[4] !== 8'h5A) begin
      bad++; $display("FAIL b2b_reg4: got %h want 5a", mem[4]);
    end
  endtask

  task automatic test_reset_mid;
    int c, np, pc, seen;
    logic [7:0] pd;
    send(2'd2, 8'h00);
    repeat (12) @(negedge clk);
    total++;
    if ({bus.wrextb, bus.rdextb} !== 2'b10) begin
      bad++;
      $display("FAIL mid_in_rd1: got %b%b want 10",
               bus.wrextb, bus.rdextb);
    end
    rstb = 1'b0;
    #1;
    total += 2;
    if ({bus.wrextb, bus.rdextb} !== 2'b11) begin
      bad++;
      $display("FAIL mid_async_strobes: got %b%b want 11",
               bus.wrextb, bus.rdextb);
    end
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready: got %b want 1", bus.req_ready);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL mid_no_rsp: got %0d pulses want 0", seen);
    end
    xact(2'd0, 8'h03, c, np, pc, pd);
    xact(2'd1, 8'h77, c, np, pc, pd);
    xact(2'd2, 8'h00, c, np, pc, pd);
    total += 2;
    if (np !== 1) begin
      bad++; $display("FAIL mid_rd_pulses: got %0d want 1", np);
    end
    if (pd !== 8'h77) begin
      bad++; $display("FAIL mid_rd_data: got %h want 77", pd);
    end
  endtask

`ifdef SPP_HOST_AUTOINC_EN
  task automatic test_autoinc;
    int c, np, pc;
    logic [7:0] pd;
    xact(2'd0, 8'h00, c, np, pc, pd);
    xact(2'd1, 8'h66, c, np, pc, pd);
    total++;
    if (taddr !== 8'h01) begin
      bad++; $display("FAIL inc_addr1: got %h want 01", taddr);
    end
    xact(2'd0, 8'hFF, c, np, pc, pd);
    xact(2'd1, 8'h11, c, np, pc, pd);
    total += 2;
    if (mem[255] !== 8'h11) begin
      bad++; $display("FAIL inc_regff: got %h want 11", mem[255]);
    end
    if (taddr !== 8'h00) begin
      bad++; $display("FAIL inc_wrap: got %h want 00", taddr);
    end
    xact(2'd2, 8'h00, c, np, pc, pd);
    total += 4;
    if (pd !== 8'h66) begin
      bad++; $display("FAIL inc_rd_data: got %h want 66", pd);
    end
    if (pc !== 21) begin
      bad++; $display("FAIL inc_rd_latency: got %0d want 21", pc);
    end
    if (c !== 31) begin
      bad++; $display("FAIL inc_rd_len: got %0d want 31", c);
    end
    if (taddr !== 8'h01) begin
      bad++; $display("FAIL inc_rd_addr: got %h want 01", taddr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero();
    test_setaddr();
    test_write();
    test_read();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
`ifdef SPP_HOST_AUTOINC_EN
    test_autoinc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spp_host.md
# spp_host

Host-side initiator for the SRAM parallel-port protocol on the XS40 boards. It turns byte-level requests (set address, write, read) into the active-low `wrextb`/`rdextb` strobe sequences and the 8-bit data bus the board-side interface expects. For reads it collects the two 4-bit return nibbles and assembles them into one byte. It is used as the bench/host model and as the on-chip master when both ends share one clock.

## Interface
Parameters:
- `STROBE_CYC`, 4: cycles a strobe pattern is held asserted (low); minimum 3.
- `RECOVER_CYC`, 6: cycles both strobes are held high after each pulse; minimum 5.

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `rstb` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_op` input 2: 0 = SETADDR, 1 = WRITE, 2 = READ, 3 = reserved (accepted, completes as a no-op).
- `req_data` input 8: address for SETADDR, data for WRITE, ignored for READ.
- `rsp_valid` output 1: one-cycle pulse when a READ completes.
- `rsp_data` output 8: read byte; valid with `rsp_valid`, held until the next READ.
- `pp_data` output 8: parallel-port data bus toward the target.
- `wrextb` output 1: write strobe, active-low.
- `rdextb` output 1: read strobe, active-low.
- `pp_din` input 4: nibble returned by the target.

## Operation
- All outputs are registered. Reset values: `wrextb`=1, `rdextb`=1, `pp_data`=0, `rsp_valid`=0, `rsp_data`=0, `req_ready`=1.
- Request capture: on acceptance, `req_data` is latched into `pp_data`. `pp_data` stays stable until the transaction returns to IDLE.
- A down-counter times each phase: LO phases last `STROBE_CYC` cycles and HI phases last `RECOVER_CYC` cycles.
- States and strobe patterns (written as wrextb/rdextb):
  - IDLE: 1/1.
  - SETADDR: ADR_LO 0/0, then ADR_HI 1/1, then IDLE.
  - WRITE: WR_LO 0/1, then WR_HI 1/1, then IDLE.
  - READ: RD0_LO 1/0, then RD0_HI 1/1, then RD1_LO 1/0, then RD1_HI 1/1, then IDLE.
- Nibble capture:
  - On the last cycle of RD0_HI, `pp_din` is stored as the low nibble.
  - On the last cycle of RD1_HI, `pp_din` is stored as the high nibble. `rsp_data` is updated and `rsp_valid` pulses on the IDLE-entry edge.
- Back-to-back operation: a request presented during the last HI cycle is not accepted. It is accepted in the following IDLE cycle, so there is always ≥1 IDLE cycle between transactions.
- Reserved op: takes one cycle in IDLE; no strobes and no `rsp_valid`.
- `req_valid` held high while not ready: the request is held off with no side effects.

## Timing
- Target path latency: strobe edge → target sampling FF (1) → target state (1) → registered internal enable (1) → target register load (1). Because of this, the minimum HI length is 5.
- SETADDR length: 1 + `STROBE_CYC` + `RECOVER_CYC` cycles, from acceptance to `req_ready` high again.
- WRITE length: same as SETADDR.
- READ length: 1 + 2×(`STROBE_CYC` + `RECOVER_CYC`). `rsp_valid` pulses on the first cycle `req_ready` is high again.
- With defaults, SETADDR and WRITE each take 11 cycles and READ takes 21.
- Reset mid-transaction: strobes go to 1/1 immediately (asynchronous). No `rsp_valid` is produced. Host and target share `rstb` so both return to idle together.

## Configuration
- `SPP_HOST_AUTOINC_EN` defined:
  - The host keeps an 8-bit shadow address. SETADDR loads it.
  - After every WRITE or READ completes, an extra ADR_LO/ADR_HI phase drives shadow+1 (wrapping 255→0) and updates the shadow.
  - `req_ready` stays low through this phase. `rsp_valid` still pulses at the end of the READ data phases, before the increment phase.
- Undefined: no shadow register and no extra phase.

## Structure
- A shared package holds:
  - the `req_op` encoding constants;
  - the state enum for `spp_host_state`;
  - minimum-timing constants (3, 5).
- One sub-module is natural: `spp_phase_timer`, a loadable down-counter with a `done` flag, reused for the LO and HI phases.

## Test plan
All scenarios use the board-side interface instantiated with shared `clk`/`rstb`.
- SETADDR 0x02: target address register becomes 0x02 and its 7-segment outputs show "2"; strobes return 1/1 and `req_ready` returns high after 11 cycles.
- SETADDR 0x01, then WRITE 0xA5: target register 1 = 0xA5. SETADDR 0x02, then WRITE 0x3C: register 2 = 0x3C and register 1 is unchanged.
- SETADDR 0x01, then READ: `rsp_valid` pulses exactly once with `rsp_data`=0xA5, 21 cycles after acceptance.
- READ with no prior write after reset: `rsp_data`=0x00.
- Assert `rstb` low midway through RD1_LO: strobes go to 1/1 at once and no `rsp_valid`. A following SETADDR 0x03, WRITE 0x77, READ returns 0x77.
- With `SPP_HOST_AUTOINC_EN`: SETADDR 0xFF, then WRITE 0x11 → shadow wraps to 0x00 and the target address is 0x00. A following READ returns the contents of register 0.
